alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one combinational RV32I ALU between two requesters (e.g., the EX-stage lane and an address-generation/auxiliary unit). Each cycle it selects at most one request with round-robin priority, evaluates it through the ALU, and registers the result into a single-entry response stage with valid/ready backpressure. The block holds a 1-cycle result latency and sustains one operation per cycle when the consumer does not stall.

## Interface
- TAG_W, 4, width of the requester tag passed through unchanged
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of the held response and of this cycle's accept
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_aluop  in  3  alu_ops: add=0, sll=1, sra=2, sub=3, xor=4, srl=5, or=6, and=7
- req0_a  in  32  operand a
- req0_b  in  32  operand b
- req0_tag  in  TAG_W  opaque tag
- req1_valid / req1_ready / req1_aluop / req1_a / req1_b / req1_tag: same directions, widths and meaning for requester 1
- resp_valid  out  1  response register holds a result
- resp_ready  in  1  consumer takes the response
- resp_id  out  1  requester index of the held result
- resp_tag  out  TAG_W  tag of the held result
- resp_f  out  32  ALU result

## Operation
- State: response register {resp_valid, resp_id, resp_tag, resp_f}; round-robin pointer rr (1 bit, index of the higher-priority requester).
- out_free = !resp_valid || resp_ready.
- Grant (combinational): if out_free && !flush: exactly one reqN_valid → grant N; both valid → grant rr; neither → no grant. reqN_ready = grant to N. Never both readies high.
- Requesters must not make valid depend on ready; valid/operands are held stable until ready.
- ALU: operates on the granted requester's operands. add/sub wrap modulo 2^32; sll/srl/sra use b[4:0] only; sra sign-fills from a[31]; xor/or/and bitwise.
- Accept (reqN_valid && reqN_ready): next edge loads resp_f=ALU result, resp_id=N, resp_tag=reqN_tag, resp_valid=1; rr = ~N.
- Response transfer = resp_valid && resp_ready && !flush. On transfer with no accept: resp_valid→0; data fields retain last value.
- No accept and no transfer: response register and rr unchanged.
- flush=1: readies forced 0, resp_valid→0 next edge, rr unchanged, data fields unchanged.
- Reset (async assert): resp_valid=0, resp_id=0, resp_tag=0, resp_f=0, rr=0 (requester 0 has priority first). Readies read 0 while rst high.

## Timing
- Latency: accept in cycle T → resp_valid=1 with result in cycle T+1.
- Throughput: 1 op/cycle while resp_ready=1; accept and transfer in the same cycle are legal (out register refilled on the same edge).
- Stall: resp_valid && !resp_ready → both readies 0; resp_id/resp_tag/resp_f stable every cycle until transfer or flush.
- Fairness: with both requesters continuously valid and no stall, grants alternate strictly; neither waits more than 1 accept.
- Simultaneous flush and resp_ready: flush dominates, no transfer counted.
- Reset mid-stream: held response discarded immediately (no clock edge required); in-flight requester must re-present after reset release.
- No combinational path from resp_ready to resp_* outputs; resp_ready → reqN_ready is combinational.

## Test plan
- req0 add a=5 b=7 tag=3, resp_ready=1 → req0_ready=1 cycle T; cycle T+1 resp_valid=1, resp_id=0, resp_tag=3, resp_f=12; resp_valid=0 at T+2.
- Both valid continuously after reset, resp_ready=1: req0 sub 1-2, req1 sra a=0x80000000 b=4 → grants 0,1,0,1; resp_f alternates 0xFFFFFFFF, 0xF8000000; one result per cycle.
- Shift masking: req1 sll a=1 b=33 → resp_f=2; srl a=0x80000000 b=31 → resp_f=1.
- Backpressure: response held, resp_ready=0 for 3 cycles with both requests valid → both readies 0, resp fields constant; raise resp_ready → transfer and accept of rr requester in same cycle, new result next cycle.
- Flush with resp_valid=1 and req0 valid → req0_ready=0, resp_valid=0 next cycle, rr unchanged; next grant follows prior rr.
- Assert rst mid-stream between clock edges → resp_valid, resp_id, resp_tag, resp_f read 0 immediately; after release both valid → req0 granted first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one combinational RV32I ALU.
// Round-robin grant, one-entry registered response stage with valid/ready.
module alu_share_arbiter #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_aluop,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_aluop,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,

  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_f
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SLL = 3'd1;
  localparam logic [OP_W-1:0] OP_SRA = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SRL = 3'd5;
  localparam logic [OP_W-1:0] OP_OR  = 3'd6;
  localparam logic [OP_W-1:0] OP_AND = 3'd7;

  // One requester's operation as seen by the ALU and response stage
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t                req0_pl;
  req_t                req1_pl;
  req_t                sel_pl;
  logic                out_free;
  logic                grant0;
  logic                grant1;
  logic                accept;
  logic                sel_id;
  logic                rr;
  logic [SHAMT_W-1:0]  shamt;
  logic [XLEN-1:0]     alu_f;

  assign req0_pl = '{op: req0_aluop, a: req0_a, b: req0_b, tag: req0_tag};
  assign req1_pl = '{op: req1_aluop, a: req1_a, b: req1_b, tag: req1_tag};

  // Round-robin grant; blocked while the output stage is full, flushing or in reset
  always_comb begin
    out_free = !resp_valid || resp_ready;
    grant0   = 1'b0;
    grant1   = 1'b0;
    if (!rst && out_free && !flush) begin
      if (req0_valid && (!req1_valid || !rr)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;
  assign sel_id     = grant1;

  // Operand mux: requester 1 only when it holds the grant
  always_comb begin
    sel_pl = req0_pl;
    if (grant1) begin
      sel_pl = req1_pl;
    end
  end

  assign shamt = sel_pl.b[SHAMT_W-1:0];

  // Shared RV32I ALU; shifts use only the low five bits of b
  always_comb begin
    alu_f = '0;
    case (sel_pl.op)
      OP_ADD:  alu_f = sel_pl.a + sel_pl.b;
      OP_SLL:  alu_f = sel_pl.a << shamt;
      OP_SRA:  alu_f = XLEN'($signed(sel_pl.a) >>> shamt);
      OP_SUB:  alu_f = sel_pl.a - sel_pl.b;
      OP_XOR:  alu_f = sel_pl.a ^ sel_pl.b;
      OP_SRL:  alu_f = sel_pl.a >> shamt;
      OP_OR:   alu_f = sel_pl.a | sel_pl.b;
      OP_AND:  alu_f = sel_pl.a & sel_pl.b;
      default: alu_f = '0;
    endcase
  end

  // Response valid: set on accept, cleared by transfer or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
    end else if (flush || resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  // Response payload: loaded only on accept, otherwise held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_id  <= 1'b0;
      resp_tag <= '0;
      resp_f   <= '0;
    end else if (accept) begin
      resp_id  <= sel_id;
      resp_tag <= sel_pl.tag;
      resp_f   <= alu_f;
    end
  end

  // Priority pointer: the requester not just served gets priority next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= 1'b0;
    end else if (accept) begin
      rr <= ~sel_id;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed steps followed by a randomized run against
// a transaction-level reference of the arbiter and ALU.
module tb_alu_share_arbiter;

  localparam int unsigned TAG_W = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_aluop;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_aluop;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      resp_f;

  int n_pass  = 0;
  int n_total = 0;

  // reference state
  logic             m_valid;
  logic             m_id;
  logic [TAG_W-1:0] m_tag;
  logic [31:0]      m_f;
  logic             m_prio;
  logic             free;
  logic             e0;
  logic             e1;
  int               wait0;
  int               wait1;

  alu_share_arbiter #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_aluop (req0_aluop),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_aluop (req1_aluop),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_tag   (req1_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_tag   (resp_tag),
    .resp_f     (resp_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
  endtask

  task automatic check_resp(input string name, input logic v, input logic id,
                            input logic [TAG_W-1:0] tag, input logic [31:0] f);
    check({name, "_valid"}, 32'(resp_valid), 32'(v));
    check({name, "_id"},    32'(resp_id),    32'(id));
    check({name, "_tag"},   32'(resp_tag),   32'(tag));
    check({name, "_f"},     resp_f,          f);
  endtask

  task automatic check_ready(input string name, input logic r0, input logic r1);
    check({name, "_rdy0"}, 32'(req0_ready), 32'(r0));
    check({name, "_rdy1"}, 32'(req1_ready), 32'(r1));
  endtask

  // Reference ALU from the instruction definitions
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned s;
    logic [31:0] ones;
    s    = b % 32;
    ones = 32'hFFFF_FFFF;
    case (op)
      3'd0: return a + b;
      3'd1: return a << s;
      3'd2: return (a >> s) | (a[31] ? ~(ones >> s) : 32'h0);
      3'd3: return a - b;
      3'd4: return a ^ b;
      3'd5: return a >> s;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req0(input logic v, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req0_valid = v; req0_aluop = op; req0_a = a; req0_b = b; req0_tag = tag;
  endtask

  task automatic set_req1(input logic v, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req1_valid = v; req1_aluop = op; req1_a = a; req1_b = b; req1_tag = tag;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    resp_ready = 1'b0;
    set_req0(1'b0, 3'd0, 32'h0, 32'h0, '0);
    set_req1(1'b0, 3'd0, 32'h0, 32'h0, '0);
    tick();
    rst = 1'b0;
    m_valid = 1'b0; m_id = 1'b0; m_tag = '0; m_f = 32'h0; m_prio = 1'b0;
    wait0 = 0; wait1 = 0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    resp_ready = 1'b1;
    set_req0(1'b1, 3'd0, 32'd1, 32'd1, 4'd1);
    set_req1(1'b1, 3'd0, 32'd1, 32'd1, 4'd1);
    #3;
    // reset state and readies held low during reset
    check_resp("reset", 1'b0, 1'b0, '0, 32'h0);
    check_ready("reset", 1'b0, 1'b0);

    // single add, latency and drain
    do_reset();
    resp_ready = 1'b1;
    set_req0(1'b1, 3'd0, 32'd5, 32'd7, 4'd3);
    #1 check_ready("add_T", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0;
    check_resp("add_T1", 1'b1, 1'b0, 4'd3, 32'd12);
    tick();
    check("add_T2_valid", 32'(resp_valid), 32'd0);

    // alternating grants, both continuously valid
    do_reset();
    resp_ready = 1'b1;
    set_req0(1'b1, 3'd3, 32'd1, 32'd2, 4'd1);
    set_req1(1'b1, 3'd2, 32'h8000_0000, 32'd4, 4'd2);
    for (int i = 0; i < 4; i++) begin
      #1 check_ready("alt", (i % 2) == 0, (i % 2) == 1);
      tick();
      if (i % 2 == 0) check_resp("alt_r0", 1'b1, 1'b0, 4'd1, 32'hFFFF_FFFF);
      else            check_resp("alt_r1", 1'b1, 1'b1, 4'd2, 32'hF800_0000);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // shift amount masking
    set_req1(1'b1, 3'd1, 32'd1, 32'd33, 4'd5);
    #1 check_ready("sll", 1'b0, 1'b1);
    tick();
    check_resp("sll", 1'b1, 1'b1, 4'd5, 32'd2);
    set_req1(1'b1, 3'd5, 32'h8000_0000, 32'd31, 4'd6);
    #1 check_ready("srl", 1'b0, 1'b1);
    tick();
    check_resp("srl", 1'b1, 1'b1, 4'd6, 32'd1);
    req1_valid = 1'b0;
    tick();
    check("drain_valid", 32'(resp_valid), 32'd0);

    // backpressure: hold 3 cycles, then transfer and accept together
    resp_ready = 1'b0;
    set_req0(1'b1, 3'd0, 32'd10, 32'd20, 4'd4);
    set_req1(1'b1, 3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd9);
    #1 check_ready("bp_first", 1'b1, 1'b0);
    tick();
    check_resp("bp_first", 1'b1, 1'b0, 4'd4, 32'd30);
    for (int i = 0; i < 3; i++) begin
      #1 check_ready("bp_stall", 1'b0, 1'b0);
      check_resp("bp_hold", 1'b1, 1'b0, 4'd4, 32'd30);
      tick();
    end
    resp_ready = 1'b1;
    #1 check_ready("bp_release", 1'b0, 1'b1);
    tick();
    check_resp("bp_next", 1'b1, 1'b1, 4'd9, 32'hFF00_FF00);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // flush kills held response and accept, priority pointer kept
    set_req0(1'b1, 3'd6, 32'd3, 32'd5, 4'd6);
    #1 check_ready("pre_flush", 1'b1, 1'b0);
    tick();
    check_resp("pre_flush", 1'b1, 1'b0, 4'd6, 32'd7);
    flush = 1'b1;
    #1 check_ready("flush", 1'b0, 1'b0);
    tick();
    flush = 1'b0;
    check_resp("post_flush", 1'b0, 1'b0, 4'd6, 32'd7);
    set_req1(1'b1, 3'd7, 32'hFF, 32'h0F, 4'd2);
    #1 check_ready("flush_rr", 1'b0, 1'b1);
    tick();
    check_resp("flush_rr", 1'b1, 1'b1, 4'd2, 32'h0F);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // asynchronous reset between edges
    resp_ready = 1'b0;
    set_req0(1'b1, 3'd0, 32'd5, 32'd7, 4'd3);
    tick();
    check_resp("pre_rst", 1'b1, 1'b0, 4'd3, 32'd12);
    #1 rst = 1'b1;
    #1 check_resp("async_rst", 1'b0, 1'b0, '0, 32'h0);
    check_ready("async_rst", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    set_req1(1'b1, 3'd0, 32'd1, 32'd1, 4'd8);
    #1 check_ready("post_rst", 1'b1, 1'b0);
    tick();
    check_resp("post_rst", 1'b1, 1'b0, 4'd3, 32'd12);

    // randomized run against the reference
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0)
        set_req0(1'b1, 3'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                 TAG_W'($urandom));
      if (!req1_valid && $urandom_range(0, 2) != 0)
        set_req1(1'b1, 3'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                 TAG_W'($urandom));
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      #1;
      free = !m_valid || resp_ready;
      e0 = free && !flush && req0_valid && (!req1_valid || m_prio == 1'b0);
      e1 = free && !flush && req1_valid && !e0;
      check_ready("rnd", e0, e1);
      if (e0) begin
        check("rnd_fair0", 32'(wait0 <= 1), 32'd1);
        m_valid = 1'b1; m_id = 1'b0; m_tag = req0_tag;
        m_f = ref_alu(req0_aluop, req0_a, req0_b); m_prio = 1'b1;
        wait0 = 0;
        if (req1_valid) wait1++;
      end else if (e1) begin
        check("rnd_fair1", 32'(wait1 <= 1), 32'd1);
        m_valid = 1'b1; m_id = 1'b1; m_tag = req1_tag;
        m_f = ref_alu(req1_aluop, req1_a, req1_b); m_prio = 1'b0;
        wait1 = 0;
        if (req0_valid) wait0++;
      end else if (flush || resp_ready) begin
        m_valid = 1'b0;
      end
      tick();
      flush = 1'b0;
      if (e0) req0_valid = 1'b0;
      if (e1) req1_valid = 1'b0;
      check_resp("rnd", m_valid, m_id, m_tag, m_f);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
